// File: rtl/dma_apb_regfile.sv
// dma_apb_regfile: NUM_CH-channel DMA register bank behind an APB slave (write zero-wait, read one wait state, PSLVERR, strobes, W1C status, irq)
module dma_apb_regfile #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [STRB_WIDTH-1:0]          PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_CH*8*DATA_WIDTH-1:0] cfg_regs,
  output logic [NUM_CH*8-1:0]            wr_pulse,
  input  logic [NUM_CH-1:0]              hw_done,
  input  logic [NUM_CH*3-1:0]            hw_status_set,
  input  logic [NUM_CH-1:0]              hw_upd_valid,
  input  logic [NUM_CH*3*DATA_WIDTH-1:0] hw_upd_data,
  output logic [NUM_CH-1:0]              irq
);
  localparam int CB = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, W_ACC, R_WAIT, R_ACC} state_t;
  state_t state, state_nx;
  logic [CB+2:0] idx;
  logic [31:0] ch_full;
  logic [DATA_WIDTH-1:0] rsel;
  logic en_sel, addr_err, err, we, pslverr_q;
  function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old);
    merge = old;
    for (int i = 0; i < STRB_WIDTH; i++)
      if (PSTRB[i]) merge[8*i +: 8] = PWDATA[8*i +: 8];
  endfunction
  assign idx      = {PADDR[8+CB-1:8], PADDR[4:2]};
  assign ch_full  = 32'(PADDR[ADDR_WIDTH-1:8]);
  assign rsel     = cfg_regs[{idx, 5'd0} +: DATA_WIDTH];
  assign en_sel   = cfg_regs[{PADDR[8+CB-1:8], 8'd0}];
  assign addr_err = ch_full >= 32'(NUM_CH) || |PADDR[7:5] || |PADDR[1:0];
  assign err      = addr_err || (PWRITE && PADDR[4:2] >= 3'd4 && PADDR[4:2] != 3'd7 && en_sel);
  assign we       = state == W_ACC && PSEL && PENABLE && !err;
  assign PREADY   = state == W_ACC || state == R_ACC;
  assign PSLVERR  = (state == W_ACC && err) || pslverr_q;
  always_comb
    state_nx = state == IDLE && PSEL && !PENABLE ? (PWRITE ? W_ACC : R_WAIT)
             : state == R_WAIT && PSEL ? R_ACC : IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      PRDATA    <= '0;
      pslverr_q <= 1'b0;
      wr_pulse  <= '0;
    end else begin
      state     <= state_nx;
      pslverr_q <= state == R_WAIT && PSEL && err;
      wr_pulse  <= we ? {{(NUM_CH*8-1){1'b0}}, 1'b1} << idx : '0;
      if (state == R_WAIT && PSEL)
        PRDATA <= err ? '0 : rsel & (PADDR[4:2] == 3'd0 ? DATA_WIDTH'(1) : {DATA_WIDTH{1'b1}});
    end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic en, stop, irq_q;
    logic [2:0] st, ie, clr;
    logic [DATA_WIDTH-1:0] ctrl, src, dst, xs, link;
    logic [7:0] w;
    assign w   = we && ch_full == c ? 8'd1 << PADDR[4:2] : 8'd0;
    assign clr = w[1] && PSTRB[0] ? PWDATA[2:0] : 3'd0;
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        en    <= 1'b0;
        stop  <= 1'b0;
        st    <= '0;
        ie    <= '0;
        ctrl  <= '0;
        src   <= '0;
        dst   <= '0;
        xs    <= '0;
        link  <= '0;
        irq_q <= 1'b0;
      end else begin
        en    <= w[0] && PSTRB[0] ? PWDATA[0] : en && !hw_done[c];
        stop  <= w[0] && PSTRB[0] && PWDATA[1];
        st    <= (st & ~clr) | hw_status_set[3*c +: 3];
        ie    <= w[2] && PSTRB[0] ? PWDATA[2:0] : ie;
        ctrl  <= w[3] ? merge(ctrl) : ctrl;
        src   <= w[4] ? merge(src) : hw_upd_valid[c] ? hw_upd_data[DATA_WIDTH*(3*c) +: DATA_WIDTH] : src;
        dst   <= w[5] ? merge(dst) : hw_upd_valid[c] ? hw_upd_data[DATA_WIDTH*(3*c+1) +: DATA_WIDTH] : dst;
        xs    <= w[6] ? merge(xs) : hw_upd_valid[c] ? hw_upd_data[DATA_WIDTH*(3*c+2) +: DATA_WIDTH] : xs;
        link  <= w[7] ? merge(link) & ~DATA_WIDTH'(3) : link;
        irq_q <= |(st & ie);
      end
    assign irq[c] = irq_q;
    assign cfg_regs[DATA_WIDTH*(8*c+0) +: DATA_WIDTH] = DATA_WIDTH'({stop, en});
    assign cfg_regs[DATA_WIDTH*(8*c+1) +: DATA_WIDTH] = DATA_WIDTH'(st);
    assign cfg_regs[DATA_WIDTH*(8*c+2) +: DATA_WIDTH] = DATA_WIDTH'(ie);
    assign cfg_regs[DATA_WIDTH*(8*c+3) +: DATA_WIDTH] = ctrl;
    assign cfg_regs[DATA_WIDTH*(8*c+4) +: DATA_WIDTH] = src;
    assign cfg_regs[DATA_WIDTH*(8*c+5) +: DATA_WIDTH] = dst;
    assign cfg_regs[DATA_WIDTH*(8*c+6) +: DATA_WIDTH] = xs;
    assign cfg_regs[DATA_WIDTH*(8*c+7) +: DATA_WIDTH] = link;
  end
endmodule

// File: doc/dma_apb_regfile.md
Name: dma_apb_regfile

Overview:
Parametrised multi-channel APB register file for the DMA. It combines the APB slave and the per-channel register bank in one clocked block with NUM_CH identical channel register sets. Compared with the single-channel bank it adds a registered read path with one wait state, PSLVERR decoding, byte strobes, W1C status and per-channel interrupts. It sits between the APB interconnect and the channel engines, which take configuration from it and push status and progress back into it.

Parameters:
NUM_CH, 4, number of channel register sets (1..16)
DATA_WIDTH, 32, APB data width (fixed at 32 for this generation)
ADDR_WIDTH, 12, PADDR width; must be >= 8+clog2(NUM_CH)
STRB_WIDTH, DATA_WIDTH/8, PSTRB width

Ports:
clk  in  1  sole clock; APB and register logic both use it
reset  in  1  asynchronous, active-high reset
PADDR  in  ADDR_WIDTH  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB enable
PWRITE  in  1  APB direction
PWDATA  in  DATA_WIDTH  APB write data
PSTRB  in  STRB_WIDTH  APB byte strobes
PRDATA  out  DATA_WIDTH  APB read data, registered
PREADY  out  1  APB ready
PSLVERR  out  1  APB error, valid only while PREADY=1
cfg_regs  out  NUM_CH*8*DATA_WIDTH  all registers, flattened as {ch, reg}, channel 0 / reg 0 in the LSBs
wr_pulse  out  NUM_CH*8  one-cycle pulse per register on a committed APB write
hw_done  in  NUM_CH  channel finished; clears CMD.ENABLE
hw_status_set  in  NUM_CH*3  per-channel STATUS bit set requests
hw_upd_valid  in  NUM_CH  load SRCADDR, DESADDR and XSIZE from hw_upd_data
hw_upd_data  in  NUM_CH*3*DATA_WIDTH  per channel {XSIZE, DESADDR, SRCADDR}
irq  out  NUM_CH  per-channel interrupt, registered

Behaviour:
- Address decode:
  - ch = PADDR[8+CB-1:8], where CB = max(1, clog2(NUM_CH)); reg = PADDR[4:2].
  - Offsets: 0x00 CMD, 0x04 STATUS, 0x08 INTREN, 0x0C CTRL, 0x10 SRCADDR, 0x14 DESADDR, 0x18 XSIZE, 0x1C LINKADDR.
- Error decode: PSLVERR=1 for any of:
  - ch >= NUM_CH;
  - PADDR[7:5] != 0;
  - PADDR[1:0] != 0;
  - a write to SRCADDR, DESADDR or XSIZE while that channel's CMD.ENABLE=1.
  An errored access does not change any state. An errored read returns PRDATA=0.
- FSM states: IDLE, W_ACC, R_WAIT, R_ACC.
  - IDLE: PSEL&!PENABLE&PWRITE -> W_ACC; PSEL&!PENABLE&!PWRITE -> R_WAIT.
  - W_ACC: PREADY=1 (zero wait). The write commits on this edge; wr_pulse fires the next cycle; -> IDLE.
  - R_WAIT: PREADY=0. Read data and error are captured into PRDATA and PSLVERR; -> R_ACC.
  - R_ACC: PREADY=1; -> IDLE.
  - PSEL dropped mid-transfer: return to IDLE with no commit.
- Byte strobes: only lanes with PSTRB[i]=1 are written. PSTRB=0 is a legal no-op write and still pulses wr_pulse.
- CMD register:
  - bit0 ENABLE (RW);
  - bit1 STOP, write-1 pulse that is visible in cfg_regs for one cycle and reads as 0;
  - other bits are reserved and read 0.
  - hw_done[ch] clears ENABLE. If an APB write sets ENABLE in the same cycle, the APB write wins.
- STATUS register:
  - bits [2:0] = DONE, ERR, STOPPED; W1C via lane 0.
  - hw_status_set sets bits. A simultaneous hw set and SW clear of the same bit leaves the bit set.
  - Upper bits read 0.
- Hardware update: hw_upd_valid loads SRCADDR, DESADDR and XSIZE in one cycle. This cannot conflict with APB, because APB writes to these registers are rejected while ENABLE=1. With ENABLE=0 and a same-cycle APB write to one of these registers, the APB write wins for that register.
- Other registers: INTREN[2:0] is RW. CTRL and LINKADDR are full 32-bit RW. LINKADDR[1:0] is forced to 0.
- irq[ch] is registered: irq[ch] <= |(STATUS[2:0] & INTREN[2:0]), i.e. one cycle after the status change.
- Reset values: all registers, PRDATA, PREADY, PSLVERR, wr_pulse and irq are 0; the FSM is in IDLE. A reset mid-transfer aborts the transfer, and the master sees PREADY=0 until the next setup phase.

Test Plan:
- Write 0xDEADBEEF to ch2 CTRL (0x20C), PSTRB=0xF, then read it back -> the write completes with zero wait; wr_pulse[2*8+3] pulses once; the read has one PREADY=0 cycle, then PRDATA=0xDEADBEEF, PSLVERR=0.
- Write 0x11223344 to ch0 SRCADDR with PSTRB=0x5, over a prior value of 0xAABBCCDD -> SRCADDR reads 0xAA22CC44.
- With NUM_CH=4: access 0x404 (ch4), 0x020 (offset) and 0x002 (misaligned) -> PSLVERR=1 on each; PRDATA=0; no register changes; no wr_pulse.
- Write CMD=1 to ch1, then write ch1 XSIZE -> PSLVERR=1 and XSIZE unchanged. Then pulse hw_upd_valid[1] with {0x40, 0x2000, 0x1000} -> XSIZE=0x40, DESADDR=0x2000, SRCADDR=0x1000. Then pulse hw_done[1] -> CMD reads 0.
- Set INTREN ch3 = 0x1 and pulse hw_status_set DONE -> irq[3]=1 one cycle later. In one cycle, W1C 0x1 plus another DONE set -> STATUS stays 0x1. A lone W1C 0x1 -> STATUS=0 and irq[3] drops the next cycle.
- Assert reset during R_WAIT -> PREADY=0, PRDATA=0, all cfg_regs=0 and irq=0 immediately (asynchronous); the next read of 0x0C returns 0.
